// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : quad_pkg
// Purpose  : Shared types and helpers for the quadrature step decoder.
//            Defines the 2-bit phase state {A,B}, the four phase constants,
//            direction codes, and the up-sequence successor function.
// Revision : 1.0  initial release
// ============================================================================
package quad_pkg;

  // Phase state is packed as {A, B}
  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Successor of a phase state when rotating in the "up" direction:
  // 00 -> 01 -> 11 -> 10 -> 00
  function automatic phase_t qnext(input phase_t s);
    phase_t n;
    case (s)
      PH_00:   n = PH_01;
      PH_01:   n = PH_11;
      PH_11:   n = PH_10;
      default: n = PH_00;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : quad_input_filter
// Purpose  : Synchronizes the asynchronous {qa,qb} pair through two flops,
//            rejects pulses shorter than FILT sampling edges, and emits a
//            one-cycle accept strobe carrying the previously accepted and the
//            newly accepted phase state. The first acceptance after reset only
//            primes the filter and produces no strobe.
// Ports    : clk      - system clock, rising edge
//            rst      - synchronous active-high reset
//            i_qa     - raw phase A (asynchronous)
//            i_qb     - raw phase B (asynchronous)
//            o_acc    - one-cycle strobe: a new state was accepted while primed
//            o_old    - accepted state before the change (valid with o_acc)
//            o_new    - accepted state after the change  (valid with o_acc)
// Revision : 1.0  initial release
// ============================================================================
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int FILT = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_qa,
  input  logic   i_qb,
  output logic   o_acc,
  output phase_t o_old,
  output phase_t o_new
);

  localparam int             c_CW        = $clog2(FILT + 1);
  localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(FILT - 1);
  localparam logic [c_CW-1:0] c_HOLD_MAX  = c_CW'(FILT);

  phase_t          r_sync1;
  phase_t          r_sync2;
  phase_t          r_filt;
  logic            r_valid;
  logic [c_CW-1:0] r_cnt;
  logic            r_acc;
  phase_t          r_old;
  phase_t          r_new;

  logic w_same;
  logic w_accept;

  // sync2 stays unchanged at this edge exactly when sync1 already equals it.
  // r_cnt holds the number of unchanged edges seen so far, so this edge is the
  // FILT-th one when r_cnt has reached FILT-1.
  assign w_same   = (r_sync1 == r_sync2);
  assign w_accept = w_same && (r_cnt >= c_HOLD_LAST) &&
                    (!r_valid || (r_sync2 != r_filt));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= PH_00;
      r_sync2 <= PH_00;
      r_filt  <= PH_00;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= 1'b0;
      r_old   <= PH_00;
      r_new   <= PH_00;
    end else begin
      r_sync1 <= {i_qa, i_qb};
      r_sync2 <= r_sync1;

      // Priming acceptance (r_valid still 0) loads filt without a strobe
      r_acc   <= w_accept && r_valid;
      r_old   <= r_filt;
      r_new   <= r_sync2;

      if (w_accept) begin
        r_filt  <= r_sync2;
        r_valid <= 1'b1;
        r_cnt   <= '0;
      end else if (!w_same) begin
        r_cnt   <= '0;
      end else if (r_cnt != c_HOLD_MAX) begin
        // Saturate once the hold requirement is met
        r_cnt   <= r_cnt + c_CW'(1);
      end
    end
  end

  assign o_acc = r_acc;
  assign o_old = r_old;
  assign o_new = r_new;

endmodule
`default_nettype wire

// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_step_decoder
// Purpose  : Converts a quadrature pair into step/direction commands and a
//            wrapping position count. Illegal (double-bit) transitions set a
//            sticky error flag.
// Ports    : clk      - system clock, rising edge
//            rst      - synchronous active-high reset
//            qa, qb   - quadrature phases, asynchronous to clk
//            en       - count enable
//            clr_err  - clears the sticky err flag (a same-cycle set wins)
//            step     - one-cycle pulse per counted legal transition
//            up_down  - direction of the last counted step, 1 = up
//            count    - CNT_W-bit wrapping position
//            err      - sticky illegal-transition flag
// Revision : 1.0  initial release
// ============================================================================
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qa,
  input  logic             qb,
  input  logic             en,
  input  logic             clr_err,
  output logic             step,
  output logic             up_down,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  logic   w_acc;
  phase_t w_old;
  phase_t w_new;
  logic   w_up;
  logic   w_dn;
  logic   w_illegal;
  logic   w_count_step;

  logic             r_step;
  logic             r_up_down;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  quad_input_filter #(
    .FILT (FILT)
  ) u_filter (
    .clk   (clk),
    .rst   (rst),
    .i_qa  (qa),
    .i_qb  (qb),
    .o_acc (w_acc),
    .o_old (w_old),
    .o_new (w_new)
  );

  // The filter only strobes on a real change, so a transition is either one
  // step along the cycle in some direction or a double-bit jump.
  assign w_up         = (w_new == qnext(w_old));
  assign w_dn         = (w_old == qnext(w_new));
  assign w_illegal    = w_acc && ((w_old ^ w_new) == 2'b11);
  assign w_count_step = w_acc && en && (w_up || w_dn);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step    <= 1'b0;
      r_up_down <= DIR_UP;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_step <= w_count_step;

      if (w_count_step) begin
        r_up_down <= w_up ? DIR_UP : DIR_DN;
        r_count   <= w_up ? (r_count + CNT_W'(1)) : (r_count - CNT_W'(1));
      end

      if (w_illegal) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign step    = r_step;
  assign up_down = r_up_down;
  assign count   = r_count;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_step_decoder
// Purpose  : Self-checking bench for quad_step_decoder. Directed scenarios
//            followed by random transitions, compared every cycle against a
//            position/direction/error model built on gray-code index
//            arithmetic.
// Revision : 1.0  initial release
// ============================================================================
module tb_quad_step_decoder;

  localparam int CNT_W   = 4;
  localparam int FILT    = 2;
  localparam int STEP_AT = FILT + 2;   // cycles after sync1 capture
  localparam int MOD     = 1 << CNT_W;

  logic             clk     = 1'b0;
  logic             rst     = 1'b1;
  logic             qa      = 1'b0;
  logic             qb      = 1'b0;
  logic             en      = 1'b1;
  logic             clr_err = 1'b0;
  logic             step;
  logic             up_down;
  logic [CNT_W-1:0] count;
  logic             err;

  int checks   = 0;
  int failures = 0;

  // Reference state
  int         m_count  = 0;
  logic       m_dir    = 1'b1;
  logic       m_err    = 1'b0;
  bit         m_primed = 1'b0;
  logic [1:0] m_last   = 2'b00;

  always #5 clk = ~clk;

  quad_step_decoder #(
    .CNT_W (CNT_W),
    .FILT  (FILT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .qa      (qa),
    .qb      (qb),
    .en      (en),
    .clr_err (clr_err),
    .step    (step),
    .up_down (up_down),
    .count   (count),
    .err     (err)
  );

  // Position of a phase on the quadrature cycle 00,01,11,10
  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_step);
    check({tag, ".step"},    32'(step),    32'(exp_step));
    check({tag, ".count"},   32'(count),   32'(m_count));
    check({tag, ".up_down"}, 32'(up_down), 32'(m_dir));
    check({tag, ".err"},     32'(err),     32'(m_err));
  endtask

  // Drive a new phase value (called at a negedge) and hold it for 'hold'
  // cycles, checking outputs every cycle. clr_err is high only at the edge
  // of loop index clr_at (-1 for never).
  task automatic apply(input logic [1:0] v, input int hold, input int clr_at);
    int   d;
    bit   will_step;
    bit   will_err;
    int   nxt_count;
    logic nxt_dir;
    will_step = 1'b0;
    will_err  = 1'b0;
    nxt_count = m_count;
    nxt_dir   = m_dir;
    if (m_primed && (v != m_last)) begin
      d = (gidx(v) - gidx(m_last) + 4) % 4;
      if (d == 2) begin
        will_err = 1'b1;
      end else if (en) begin
        will_step = 1'b1;
        if (d == 1) begin
          nxt_count = (m_count + 1) % MOD;
          nxt_dir   = 1'b1;
        end else begin
          nxt_count = (m_count + MOD - 1) % MOD;
          nxt_dir   = 1'b0;
        end
      end
    end
    m_primed = 1'b1;
    m_last   = v;
    {qa, qb} = v;
    for (int i = 0; i < hold; i++) begin
      clr_err = (i == clr_at);
      @(posedge clk);
      if (i == STEP_AT) begin
        m_count = nxt_count;
        m_dir   = nxt_dir;
      end
      if ((i == STEP_AT) && will_err) m_err = 1'b1;
      else if (clr_err)               m_err = 1'b0;
      @(negedge clk);
      check_all($sformatf("v%0b_c%0d", v, i), (i == STEP_AT) && will_step);
    end
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    m_count  = 0;
    m_dir    = 1'b1;
    m_err    = 1'b0;
    m_primed = 1'b0;
    check_all("reset", 1'b0);
  endtask

  initial begin
    int          hold;
    int          clr_at;
    logic [1:0]  v;

    // Power-on reset and priming with 00
    {qa, qb} = 2'b00;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    apply(2'b00, 10, -1);

    // Up sequence
    en = 1'b1;
    apply(2'b01, 8, -1);
    apply(2'b11, 8, -1);
    apply(2'b10, 8, -1);
    apply(2'b00, 8, -1);

    // Down sequence, crossing 0 -> all-ones
    apply(2'b10, 8, -1);
    apply(2'b11, 8, -1);
    apply(2'b01, 8, -1);
    apply(2'b00, 8, -1);
    apply(2'b10, 8, -1);
    apply(2'b11, 8, -1);
    apply(2'b01, 8, -1);
    apply(2'b00, 8, -1);

    // Up across all-ones -> 0
    apply(2'b01, 8, -1);
    apply(2'b11, 8, -1);
    apply(2'b10, 8, -1);
    apply(2'b00, 8, -1);

    // One-cycle glitch on qa must not reach the filter
    {qa, qb} = 2'b01;
    @(posedge clk);
    @(negedge clk);
    apply(2'b00, 10, -1);

    // Illegal jump, then illegal with simultaneous clear, then clear alone
    apply(2'b11, 8, -1);
    apply(2'b00, 8, STEP_AT);
    apply(2'b00, 4, 0);

    // Disabled counting, re-enable while stable, then count again
    en = 1'b0;
    apply(2'b01, 8, -1);
    apply(2'b11, 8, -1);
    en = 1'b1;
    apply(2'b11, 8, -1);
    apply(2'b10, 8, -1);

    // Reach 0101, reset mid-operation, re-prime, then count from 0
    apply(2'b00, 8, -1);
    apply(2'b01, 8, -1);
    apply(2'b11, 8, -1);
    apply(2'b10, 8, -1);
    check("count_before_reset", 32'(count), 32'd5);
    do_reset();
    apply(2'b10, 10, -1);
    apply(2'b00, 8, -1);

    // Random transitions (legal, illegal, repeated), random enable/clear
    for (int n = 0; n < 60; n++) begin
      v      = 2'($urandom_range(0, 3));
      en     = ($urandom_range(0, 3) != 0);
      hold   = $urandom_range(6, 10);
      clr_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, hold - 1) : -1;
      apply(v, hold, clr_at);
      if ($urandom_range(0, 19) == 0) begin
        do_reset();
        apply({qa, qb}, 10, -1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Converts a two-phase quadrature pair (qa, qb) into step/direction commands and a wrapping position count of the same shape as our up/down counter.
- Counter direction comes from input phase instead of an explicit control.
- Sits between the encoder input pins and the counting/display logic.
- Includes a 2-FF synchronizer, glitch filter, transition decoder and illegal-transition flag.

Parameters:
- CNT_W, 4, width of position count.
- FILT, 2, consecutive sampling edges the synchronized input must hold before being accepted (FILT >= 1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- qa  in  1  quadrature phase A, asynchronous to clk
- qb  in  1  quadrature phase B, asynchronous to clk
- en  in  1  count enable
- clr_err  in  1  clears sticky err
- step  out  1  one-cycle pulse per accepted legal transition while en=1
- up_down  out  1  direction of last counted step, 1 = up, 0 = down
- count  out  CNT_W  position, wraps
- err  out  1  sticky illegal-transition flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: count=0, step=0, up_down=1, err=0, sync regs=00, filt=00, valid=0, stable counter=0.
- Synchronizer: {qa,qb} pass through sync1 then sync2, giving 2 flops.
- Filter:
  - The stable counter counts edges at which sync2 is unchanged from the previous edge. It restarts on any sync2 change.
  - When sync2 has been held for FILT edges and either sync2 != filt or valid=0, then filt <= sync2 and the counter clears.
- Priming: the first filter acceptance after reset sets valid=1 and loads filt only. It generates no step and no err.
- Decode, registered, using old filt -> new filt on each acceptance while valid=1:
  - Up sequence: 00->01->11->10->00.
  - Down sequence: the reverse.
  - Both bits changed: illegal. err <= 1 the next edge. No step, count and up_down unchanged.
- Counted step, legal transition with en=1, on the edge after acceptance:
  - step=1 for exactly one cycle.
  - count +/-1 modulo 2^CNT_W (all-ones up -> 0, 0 down -> all-ones).
  - up_down <= direction.
- en=0: filt still tracks, and illegal transitions still set err. No step, count and up_down hold. Re-enabling produces no spurious step.
- Latency: raw input change first captured by sync1 at edge t0. Then filt updates at edge t0+FILT+1, and step/count update at edge t0+FILT+2. With FILT=2, step is high between edges t0+4 and t0+5.
- Glitch rejection: a pulse shorter than FILT clock periods at sync2 never reaches filt.
- err: set wins over clr_err in the same cycle. Otherwise clr_err=1 clears err on the next edge.
- Reset mid-operation: all state returns to reset values on the next edge. The next acceptance is a priming event.
- Max input rate: one legal transition per FILT+2 clocks. Faster input is not guaranteed and may flag err.

Decomposition:
- Package quad_pkg:
  - 2-bit phase state type and constants PH_00, PH_01, PH_11, PH_10.
  - Direction constants DIR_UP=1, DIR_DN=0.
  - Function qnext(state) returning the up-sequence successor.
- One sub-module: quad_input_filter (synchronizer, stable counter, filt, valid, one-cycle accept strobe with old/new state).
- The top level holds decode, count, up_down, step and err.

Test Plan:
- Reset, then qa,qb held 00 for 10 cycles -> valid primes, step never pulses, count=0000, up_down=1, err=0.
- Up sequence 00->01->11->10->00, each held 8 cycles, en=1 -> four single-cycle step pulses, each FILT+2 edges after sync1 capture. count 0001,0010,0011,0100, up_down=1.
- From count=0001 apply down sequence 00->10->11 -> count 0000 then 1111 (wrap), up_down=0, two step pulses.
- 1-cycle glitch on qa (00->01->00) -> no filt change, no step, count unchanged. Then 00->11 held 8 cycles -> err=1, count unchanged. clr_err together with another illegal 11->00 -> err stays 1. clr_err alone -> err=0.
- en=0 during two up transitions -> count and up_down hold, no step. Set en=1 with input stable -> no step. Next up transition -> count+1.
- rst asserted for 1 cycle mid-sequence at count=0101 -> count=0000 next edge, first subsequent acceptance primes with no step.
